// File: rtl/craft_enc_core.sv
// Iterative CRAFT-64 encryption core: one round per clock behind a valid/ready handshake.
// The tweakey schedule and the S-box layer are small combinational helpers in this file.

module craft_sbox (
    input  logic [15:0] x,
    output logic [15:0] y
);
    function automatic logic [3:0] sbox4(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'h0: r = 4'hC;
            4'h1: r = 4'hA;
            4'h2: r = 4'hD;
            4'h3: r = 4'h3;
            4'h4: r = 4'hE;
            4'h5: r = 4'hB;
            4'h6: r = 4'hF;
            4'h7: r = 4'h7;
            4'h8: r = 4'h8;
            4'h9: r = 4'h9;
            4'hA: r = 4'h1;
            4'hB: r = 4'h5;
            4'hC: r = 4'h0;
            4'hD: r = 4'h2;
            4'hE: r = 4'h4;
            default: r = 4'h6;
        endcase
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign y[4*gi +: 4] = sbox4(x[4*gi +: 4]);
        end
    endgenerate
endmodule

module craft_key_schedule (
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    input  logic [1:0]   r,        // round index mod 4 selects the tweakey
    output logic [63:0]  tk
);
    // Tweak nibble permutation Q, nibble 0 in the top hex digit.
    localparam logic [63:0] QPERM = 64'hCAF5_E892_B374_601D;

    logic [63:0] tweak_q;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_q
            localparam int SRC = int'(QPERM[63-4*gi -: 4]);
            assign tweak_q[63-4*gi -: 4] = tweak[63-4*SRC -: 4];
        end
    endgenerate

    always_comb begin
        tk = 64'h0;
        case (r)
            2'd0:    tk = key[127:64] ^ tweak;
            2'd1:    tk = key[63:0]   ^ tweak;
            2'd2:    tk = key[127:64] ^ tweak_q;
            default: tk = key[63:0]   ^ tweak_q;
        endcase
    end
endmodule

module craft_enc_core #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    input  logic [63:0]  pt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  ct,
    output logic [7:0]   round_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS - 1);
    localparam logic [63:0] PNPERM     = 64'hFCDE_A98B_6547_1230;

    state_t       fsm_reg;
    logic [127:0] key_reg;
    logic [63:0]  tweak_reg;
    logic [63:0]  state_reg;
    logic [3:0]   rc_a_reg;
    logic [2:0]   rc_b_reg;
    logic [7:0]   round_idx_reg;
    logic [63:0]  ct_reg;
    logic         out_valid_reg;

    logic         accept;
    logic         last_round;
    logic [63:0]  round_tk;
    logic [63:0]  mc_out, arc_out, atk_out, pn_out, sb_out, round_out;

    // A finished block can be swapped for a new one on the same edge it is taken.
    assign in_ready   = (fsm_reg == IDLE) || ((fsm_reg == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_round = (round_idx_reg == LAST_ROUND);

    craft_key_schedule u_ks (
        .key   (key_reg),
        .tweak (tweak_reg),
        .r     (round_idx_reg[1:0]),
        .tk    (round_tk)
    );

    // Rows are 16-bit slices, row 0 in the top bits; only rows 0 and 1 change in MC.
    assign mc_out  = {state_reg[63:48] ^ state_reg[31:16] ^ state_reg[15:0],
                      state_reg[47:32] ^ state_reg[15:0],
                      state_reg[31:0]};
    assign arc_out = mc_out ^ {16'h0, rc_a_reg, 1'b0, rc_b_reg, 40'h0};
    assign atk_out = arc_out ^ round_tk;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pn
            localparam int SRC = int'(PNPERM[63-4*gi -: 4]);
            assign pn_out[63-4*gi -: 4] = atk_out[63-4*SRC -: 4];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_sb
            craft_sbox u_sbox (
                .x (pn_out[16*gi +: 16]),
                .y (sb_out[16*gi +: 16])
            );
        end
    endgenerate

    assign round_out = last_round ? atk_out : sb_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg       <= IDLE;
            key_reg       <= '0;
            tweak_reg     <= '0;
            state_reg     <= '0;
            rc_a_reg      <= 4'h1;
            rc_b_reg      <= 3'h1;
            round_idx_reg <= '0;
            ct_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (fsm_reg)
                RUN: begin
                    state_reg <= round_out;
                    rc_a_reg  <= {rc_a_reg[1] ^ rc_a_reg[0], rc_a_reg[3:1]};
                    rc_b_reg  <= {rc_b_reg[1] ^ rc_b_reg[0], rc_b_reg[2:1]};
                    if (last_round) begin
                        ct_reg        <= round_out;
                        out_valid_reg <= 1'b1;
                        fsm_reg       <= DONE;
                    end else begin
                        round_idx_reg <= round_idx_reg + 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        fsm_reg       <= IDLE;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
            // Loading last lets a DONE-cycle accept override the return to IDLE.
            if (accept) begin
                key_reg       <= key;
                tweak_reg     <= tweak;
                state_reg     <= pt;
                round_idx_reg <= '0;
                rc_a_reg      <= 4'h1;
                rc_b_reg      <= 3'h1;
                fsm_reg       <= RUN;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign ct        = ct_reg;
    assign round_idx = round_idx_reg;
endmodule
